// File: rtl/wb_arbiter_if.sv
// Result/writeback bundle between execution units and wb_arbiter.
// With WB_BYPASS_EN defined the bundle also carries the same-cycle bypass outputs.
interface wb_arbiter_if #(
    parameter int N_UNITS = 3,
    parameter int XLEN    = 32
);
    logic [N_UNITS-1:0]      res_valid;
    logic [N_UNITS-1:0]      res_ready;
    logic [N_UNITS*5-1:0]    res_rd;
    logic [N_UNITS*XLEN-1:0] res_rd_val;
    logic [N_UNITS-1:0]      res_br_valid;
    logic [N_UNITS*XLEN-1:0] res_br_target;

    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_target;
    logic                    flush;

`ifdef WB_BYPASS_EN
    logic                    byp_valid;
    logic [4:0]              byp_rd;
    logic [XLEN-1:0]         byp_val;

    modport slave (
        input  res_valid, res_rd, res_rd_val, res_br_valid, res_br_target,
        output res_ready, rf_we, rf_waddr, rf_wdata,
        output redirect_valid, redirect_target, flush,
        output byp_valid, byp_rd, byp_val
    );
    modport master (
        output res_valid, res_rd, res_rd_val, res_br_valid, res_br_target,
        input  res_ready, rf_we, rf_waddr, rf_wdata,
        input  redirect_valid, redirect_target, flush,
        input  byp_valid, byp_rd, byp_val
    );
`else
    modport slave (
        input  res_valid, res_rd, res_rd_val, res_br_valid, res_br_target,
        output res_ready, rf_we, rf_waddr, rf_wdata,
        output redirect_valid, redirect_target, flush
    );
    modport master (
        output res_valid, res_rd, res_rd_val, res_br_valid, res_br_target,
        input  res_ready, rf_we, rf_waddr, rf_wdata,
        input  redirect_valid, redirect_target, flush
    );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin grant of one execution-unit result per cycle onto
// the register-file port, with redirect/flush pulse and one drain cycle. Macro: WB_BYPASS_EN.
module wb_arbiter #(
    parameter int N_UNITS = 3,
    parameter int XLEN    = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(N_UNITS);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e             state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next, grant;
    logic               found, transfer, sel_br;
    logic [N_UNITS-1:0] onehot;
    logic [4:0]         sel_rd;
    logic [XLEN-1:0]    sel_val, sel_target;

    // Pass 0 searches ptr..N-1, pass 1 wraps to 0..ptr-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves one unassigned (no latch).
        grant      = ptr;
        found      = 1'b0;
        onehot     = '0;
        sel_rd     = '0;
        sel_val    = '0;
        sel_br     = 1'b0;
        sel_target = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (!found && bus.res_valid[i] && ((pass == 0) == (i >= int'(ptr)))) begin
                    found      = 1'b1;
                    grant      = PTR_W'(i);
                    onehot[i]  = 1'b1;
                    sel_rd     = bus.res_rd[i*5 +: 5];
                    sel_val    = bus.res_rd_val[i*XLEN +: XLEN];
                    sel_br     = bus.res_br_valid[i];
                    sel_target = bus.res_br_target[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Reset gates the grant so a transfer coincident with reset never happens.
    assign transfer      = found && (state == RUN) && !rst;
    assign bus.res_ready = transfer ? onehot : '0;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (transfer) begin
            ptr_next = (grant == PTR_W'(N_UNITS - 1)) ? '0 : grant + PTR_W'(1);
        end
        unique case (state)
            RUN:     state_next = (transfer && sel_br) ? DRAIN : RUN;
            DRAIN:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= RUN;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rf_we           <= 1'b0;
            bus.rf_waddr        <= '0;
            bus.rf_wdata        <= '0;
            bus.redirect_valid  <= 1'b0;
            bus.redirect_target <= '0;
            bus.flush           <= 1'b0;
        end else begin
            bus.rf_we          <= transfer && (sel_rd != 5'd0);
            bus.redirect_valid <= transfer && sel_br;
            bus.flush          <= transfer && sel_br;
            if (transfer) begin
                bus.rf_waddr <= sel_rd;
                bus.rf_wdata <= sel_val;
            end
            if (transfer && sel_br) begin
                bus.redirect_target <= sel_target;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign bus.byp_valid = transfer && (sel_rd != 5'd0);
    assign bus.byp_rd    = sel_rd;
    assign bus.byp_val   = sel_val;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a rotating-priority reference model.
module tb_wb_arbiter;
    localparam int N  = 3;
    localparam int X  = 32;
    localparam int OW = 2 * X + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter_if #(.N_UNITS(N), .XLEN(X)) bus ();
    wb_arbiter #(.N_UNITS(N), .XLEN(X)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: rotating priority, a drain flag, expected registered outputs.
    int            m_ptr;
    bit            m_drain;
    logic          m_we, m_rv, m_flush;
    logic [4:0]    m_waddr;
    logic [X-1:0]  m_wdata, m_target;

    function automatic int model_grant();
        if (rst || m_drain) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (bus.res_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        int g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [4:0]   unit_rd(int i);  return bus.res_rd[i*5 +: 5];         endfunction
    function automatic logic [X-1:0] unit_val(int i); return bus.res_rd_val[i*X +: X];     endfunction
    function automatic logic [X-1:0] unit_tgt(int i); return bus.res_br_target[i*X +: X];  endfunction

    function automatic logic [OW-1:0] exp_out();
        return {m_we, m_waddr, m_wdata, m_rv, m_target, m_flush};
    endfunction

    function automatic logic [OW-1:0] obs_out();
        return {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.redirect_valid, bus.redirect_target, bus.flush};
    endfunction

    task automatic model_commit();
        int g = model_grant();
        if (rst) begin
            m_ptr = 0; m_drain = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
            m_rv = 1'b0; m_target = '0; m_flush = 1'b0;
        end else begin
            m_we = (g >= 0) && (unit_rd(g) != 5'd0);
            m_rv = (g >= 0) && bus.res_br_valid[g];
            if (g >= 0) begin
                m_waddr = unit_rd(g);
                m_wdata = unit_val(g);
                m_ptr   = (g + 1) % N;
            end
            if (m_rv) m_target = unit_tgt(g);
            m_flush = m_rv;
            m_drain = m_rv;
        end
    endtask

    // Samples the model on pre-edge inputs, then moves to 1 time unit past the edge.
    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input bit v, input logic [4:0] rd, input logic [X-1:0] val,
                            input bit br, input logic [X-1:0] tgt);
        bus.res_valid[i]          = v;
        bus.res_rd[i*5 +: 5]      = rd;
        bus.res_rd_val[i*X +: X]  = val;
        bus.res_br_valid[i]       = br;
        bus.res_br_target[i*X +: X] = tgt;
    endtask

    task automatic clear_units();
        for (int i = 0; i < N; i++) set_unit(i, 1'b0, 5'd0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_unit(i, 1'b1, 5'(i + 1), X'(32'h100 + i), 1'b1, X'(32'h4000));
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.res_ready !== '0) begin
                errors++; $display("FAIL reset_ready got %b want %b", bus.res_ready, {N{1'b0}});
            end
            advance();
            checks++;
            if (obs_out() !== {OW{1'b0}}) begin
                errors++; $display("FAIL reset_outputs got %h want %h", obs_out(), {OW{1'b0}});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) set_unit(i, 1'b1, 5'(i + 1), X'(32'h11 * (i + 1)), 1'b0, '0);
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (bus.res_ready !== N'(1 << (c % N))) begin
                errors++; $display("FAIL rr_ready[%0d] got %b want %b", c, bus.res_ready, N'(1 << (c % N)));
            end
            advance();
            checks++;
            if (obs_out() !== exp_out() || bus.rf_waddr !== 5'((c % N) + 1)) begin
                errors++; $display("FAIL rr_write[%0d] got %h want %h", c, obs_out(), exp_out());
            end
        end
        clear_units();
    endtask

    task automatic test_rd_zero();
        set_unit(2, 1'b1, 5'd0, X'(32'hDEAD), 1'b0, '0);
        #1;
        checks++;
        if (bus.res_ready !== model_ready()) begin
            errors++; $display("FAIL rd0_ready got %b want %b", bus.res_ready, model_ready());
        end
        advance();
        checks++;
        if (obs_out() !== exp_out() || bus.rf_we !== 1'b0) begin
            errors++; $display("FAIL rd0_write got %h want %h", obs_out(), exp_out());
        end
        clear_units();
    endtask

    task automatic test_jalr();
        // cycle 0: JALR from unit 0 with units 1/2 also pending; then drain; then unit 1.
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                set_unit(0, 1'b1, 5'd1, X'(32'h104), 1'b1, X'(32'h2000));
                set_unit(1, 1'b1, 5'd4, X'(32'h44), 1'b0, '0);
                set_unit(2, 1'b1, 5'd5, X'(32'h55), 1'b0, '0);
            end else if (c == 1) begin
                set_unit(0, 1'b0, 5'd0, '0, 1'b0, '0);
            end
            #1;
            checks++;
            if (bus.res_ready !== model_ready()) begin
                errors++; $display("FAIL jalr_ready[%0d] got %b want %b", c, bus.res_ready, model_ready());
            end
            advance();
            checks++;
            if (obs_out() !== exp_out()) begin
                errors++; $display("FAIL jalr_out[%0d] got %h want %h", c, obs_out(), exp_out());
            end
            if (c == 2) set_unit(1, 1'b0, 5'd0, '0, 1'b0, '0);
        end
        clear_units();
    endtask

    task automatic test_wrap();
        // unit 1 alone moves ptr to 2; then 3'b011 wraps to unit 0, then unit 1.
        logic [N-1:0] want [3] = '{3'b010, 3'b001, 3'b010};
        set_unit(0, 1'b0, 5'd7, X'(32'h70), 1'b0, '0);
        set_unit(1, 1'b1, 5'd6, X'(32'h60), 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) bus.res_valid = 3'b011;
            #1;
            checks++;
            if (bus.res_ready !== want[c] || bus.res_ready !== model_ready()) begin
                errors++; $display("FAIL wrap_ready[%0d] got %b want %b", c, bus.res_ready, want[c]);
            end
            advance();
            checks++;
            if (obs_out() !== exp_out()) begin
                errors++; $display("FAIL wrap_out[%0d] got %h want %h", c, obs_out(), exp_out());
            end
        end
        clear_units();
    endtask

    task automatic test_reset_on_branch();
        set_unit(0, 1'b1, 5'd3, X'(32'h33), 1'b1, X'(32'h8000));
        set_unit(1, 1'b1, 5'd4, X'(32'h44), 1'b0, '0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.res_ready !== '0) begin
            errors++; $display("FAIL rstbr_ready got %b want %b", bus.res_ready, {N{1'b0}});
        end
        advance();
        rst = 1'b0;
        checks++;
        if (obs_out() !== {OW{1'b0}}) begin
            errors++; $display("FAIL rstbr_out got %h want %h", obs_out(), {OW{1'b0}});
        end
        set_unit(0, 1'b1, 5'd3, X'(32'h33), 1'b0, '0);
        #1;
        checks++;
        if (bus.res_ready !== 3'b001) begin
            errors++; $display("FAIL rstbr_ptr got %b want %b", bus.res_ready, 3'b001);
        end
        advance();
        clear_units();
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        set_unit(1, 1'b1, 5'd5, X'(32'hABCD), 1'b0, '0);
        #1;
        checks++;
        if ({bus.byp_valid, bus.byp_rd, bus.byp_val} !== {1'b1, 5'd5, X'(32'hABCD)}) begin
            errors++; $display("FAIL bypass got %b/%0d/%h want 1/5/abcd", bus.byp_valid, bus.byp_rd, bus.byp_val);
        end
        advance();
        checks++;
        if (obs_out() !== exp_out() || bus.rf_we !== 1'b1) begin
            errors++; $display("FAIL bypass_rf got %h want %h", obs_out(), exp_out());
        end
        clear_units();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++)
                set_unit(i, 1'($urandom), 5'($urandom_range(0, 3)), X'($urandom), ($urandom_range(0, 5) == 0), X'($urandom));
            #1;
            checks++;
            if (bus.res_ready !== model_ready()) begin
                errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, bus.res_ready, model_ready());
            end
`ifdef WB_BYPASS_EN
            begin
                int g = model_grant();
                logic want_byp = (g >= 0) && (unit_rd(g) != 5'd0);
                checks++;
                if (bus.byp_valid !== want_byp || (want_byp && {bus.byp_rd, bus.byp_val} !== {unit_rd(g), unit_val(g)})) begin
                    errors++; $display("FAIL rand_byp[%0d] got %b/%0d want %b", c, bus.byp_valid, bus.byp_rd, want_byp);
                end
            end
`endif
            advance();
            checks++;
            if (obs_out() !== exp_out()) begin
                errors++; $display("FAIL rand_out[%0d] got %h want %h", c, obs_out(), exp_out());
            end
        end
        rst = 1'b0;
        clear_units();
    endtask

    initial begin
        clear_units();
        test_reset();
        test_round_robin();
        test_rd_zero();
        test_jalr();
        test_wrap();
        test_reset_on_branch();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback stage that sits on the consumer side of the execution-unit result interface. It collects `rd`/`rd_val`/`br_valid`/`br_target` results from `N_UNITS` execution units (misc, ALU, LSU, …) over ready/valid handshakes. Each cycle it grants at most one unit, round-robin, and registers the winner onto the register-file write port. A taken branch/jump result produces a one-cycle redirect and flush pulse, followed by a one-cycle drain state.

## Interface
- `N_UNITS`, default 3: number of execution units; valid range 2–8.
- `XLEN`, default 32: data and address width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `res_valid` in N_UNITS: per-unit result valid.
- `res_ready` out N_UNITS: per-unit grant (ready); one-hot or zero.
- `res_rd` in N_UNITS*5: destination register per unit; unit i occupies bits [5i+4:5i].
- `res_rd_val` in N_UNITS*XLEN: result value per unit.
- `res_br_valid` in N_UNITS: result carries a redirect.
- `res_br_target` in N_UNITS*XLEN: redirect target per unit.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: write address.
- `rf_wdata` out XLEN: write data.
- `redirect_valid` out 1: fetch redirect pulse.
- `redirect_target` out XLEN: redirect PC.
- `flush` out 1: pipeline flush pulse, driven to fetch, decode and all execution units.

## Operation
- States:
  - RUN (reset state).
  - DRAIN.
- Arbitration in RUN:
  - Round-robin pointer `ptr` (width clog2(N_UNITS)), reset 0.
  - Grant goes to the first index i ≥ `ptr` with `res_valid[i]`; if none, search wraps to indices 0…ptr-1.
  - `res_ready[grant]`=1; every other bit of `res_ready` is 0.
  - `res_ready` is combinational from `res_valid`, `ptr` and state.
  - A transfer occurs when `res_valid[i] & res_ready[i]`.
  - On a transfer, `ptr` ← (grant+1) mod N_UNITS, with explicit wrap for non-power-of-two N_UNITS. With no transfer, `ptr` holds.
- Writeback register (loaded on transfer):
  - `rf_we` ← (rd ≠ 0).
  - `rf_waddr` ← rd.
  - `rf_wdata` ← rd_val.
  - With no transfer, `rf_we` ← 0; `rf_waddr`/`rf_wdata` hold.
- Redirect:
  - A transfer with `br_valid`=1 sets `redirect_valid`=1, `redirect_target`=br_target and `flush`=1 for exactly the next cycle.
  - The state moves to DRAIN.
  - A transfer with both rd≠0 and a redirect (JALR link) also performs its rf write.
- DRAIN:
  - `res_ready`=0 for all units.
  - Returns to RUN unconditionally after one cycle.
  - Units must drop any held result when they see `flush`; a result still valid after DRAIN is treated as new.
- `redirect_valid` and `flush` are 0 in every cycle not immediately following a redirect transfer.

## Timing
- Latency: transfer at cycle T → `rf_we`/`redirect_valid`/`flush` visible at T+1.
- Throughput: one result per cycle in RUN. After a redirect transfer at T:
  - T+1: DRAIN, no grant.
  - T+2: earliest next grant.
- Reset values:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `redirect_valid`=0, `redirect_target`=0, `flush`=0.
  - `ptr`=0, state RUN.
  - `res_ready`=0 during the reset cycle.
- `rst` asserted mid-DRAIN or coincident with a transfer: the reset wins. The transfer has no effect, and no redirect or write appears.
- All-zero `res_valid`: no grant, `ptr` unchanged, `rf_we`=0 next cycle.
- Units must hold `res_valid` and their payload stable until granted.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `byp_valid` (1), `byp_rd` (5) and `byp_val` (XLEN).
  - These are combinational copies of the granted transfer in the same cycle as the transfer.
  - `byp_valid` = transfer & rd≠0.
  - This gives operand forwarding one cycle earlier than `rf_we`.
- Undefined: the bypass ports do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then `res_valid`=3'b111, no branches, rd = 1/2/3, values 0x11/0x22/0x33 held → grants in order 0,1,2,0,…. `rf_we` writes x1=0x11, x2=0x22, x3=0x33 on consecutive cycles starting one cycle after the first grant.
- Only unit 2 valid, rd=0, value 0xDEAD → granted; `rf_we`=0 next cycle; `ptr`=0 afterwards.
- Unit 0 delivers JALR: rd=1, rd_val=0x104, br_valid=1, target 0x2000 → next cycle `rf_we`=1 (x1=0x104), `redirect_valid`=1, `redirect_target`=0x2000, `flush`=1. The cycle after that has `res_ready`=0 despite `res_valid`=3'b110. Unit 1 is granted the following cycle.
- `ptr`=2 with `res_valid`=3'b011 → unit 0 granted (wrap-around); then `ptr`=1 → unit 1 granted.
- Assert `rst` in the same cycle as a branch transfer → next cycle `redirect_valid`=0, `flush`=0, `rf_we`=0, `ptr`=0.
- With `WB_BYPASS_EN`: grant unit 1 (rd=5, 0xABCD) → `byp_valid`=1, `byp_rd`=5, `byp_val`=0xABCD in the grant cycle; `rf_we` in the following cycle.
